// File: rtl/pc_ras_pkg.sv
// Shared definitions for the program counter with return-address stack.
`ifndef INST_DEPTH
`define INST_DEPTH 8
`endif

package pc_ras_pkg;

  // One action per unstalled cycle, chosen by fixed priority.
  typedef enum logic [2:0] {
    PC_NOP  = 3'd0,
    PC_CNT  = 3'd1,
    PC_BR   = 3'd2,
    PC_LD   = 3'd3,
    PC_CALL = 3'd4,
    PC_RET  = 3'd5
  } pc_act_e;

  // Priority: ret > call > load > branch > count > none.
  function automatic pc_act_e pc_decode(input logic ret, input logic call, input logic load,
                                        input logic branch, input logic count);
    if (ret)         return PC_RET;
    else if (call)   return PC_CALL;
    else if (load)   return PC_LD;
    else if (branch) return PC_BR;
    else if (count)  return PC_CNT;
    else             return PC_NOP;
  endfunction

endpackage

// File: rtl/pc_ras_if.sv
// Control strobes in, program address and stack status out.
`ifndef INST_DEPTH
`define INST_DEPTH 8
`endif

interface pc_ras_if #(
  parameter int unsigned ADDR_W  = `INST_DEPTH,
  parameter int unsigned OFF_W   = 8,
  parameter int unsigned DEPTH_W = 3
);
  logic              stall;
  logic              count;
  logic              load;
  logic              branch;
  logic              call;
  logic              ret;
  logic              clr_err;
  logic [ADDR_W-1:0] addr_in;
  logic [OFF_W-1:0]  offset;
  logic [ADDR_W-1:0] addr_out;
  logic [DEPTH_W-1:0] depth;
  logic              ovf_err;
  logic              unf_err;

  modport master (
    output stall, count, load, branch, call, ret, clr_err, addr_in, offset,
    input  addr_out, depth, ovf_err, unf_err
  );

  modport slave (
    input  stall, count, load, branch, call, ret, clr_err, addr_in, offset,
    output addr_out, depth, ovf_err, unf_err
  );
endinterface

// File: rtl/pc_ras_stack.sv
// Register-array LIFO holding return addresses; occupancy doubles as the write index.
module pc_ras_stack #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH_W = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [WIDTH-1:0]   push_data_i,
  output logic [WIDTH-1:0]   top_o,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [IdxW-1:0]    wr_idx, top_idx;

  assign wr_idx  = depth_q[IdxW-1:0];
  // DEPTH is a power of two, so a full stack's low bits are 0 and 0-1 lands on DEPTH-1.
  assign top_idx = depth_q[IdxW-1:0] - IdxW'(1);
  assign full_o  = (depth_q == DEPTH_W'(DEPTH));
  assign empty_o = (depth_q == '0);
  assign top_o   = mem_q[top_idx];
  assign depth_o = depth_q;

  // Occupancy update; caller never pushes when full nor pops when empty.
  always_comb begin
    depth_d = depth_q;
    if (push_i && !full_o)      depth_d = depth_q + DEPTH_W'(1);
    else if (pop_i && !empty_o) depth_d = depth_q - DEPTH_W'(1);
  end

  // Occupancy register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) depth_q <= '0;
    else         depth_q <= depth_d;
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_idx] <= push_data_i;
  end
endmodule

// File: rtl/pc_ras.sv
// Program counter with count/load/branch and call/return through a small RAS.
`ifndef INST_DEPTH
`define INST_DEPTH 8
`endif

module pc_ras
  import pc_ras_pkg::*;
#(
  parameter int unsigned ADDR_W      = `INST_DEPTH,
  parameter int unsigned OFF_W       = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned DEPTH_W     = $clog2(STACK_DEPTH) + 1
) (
  input  logic     clk,
  input  logic     rst,
  pc_ras_if.slave  bus
);
  pc_act_e           act;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push, pop;
  logic [ADDR_W-1:0] top, ret_addr, off_ext;
  logic              full, empty;
  logic [DEPTH_W-1:0] depth;

  assign act      = pc_decode(bus.ret, bus.call, bus.load, bus.branch, bus.count);
  assign ret_addr = addr_q + ADDR_W'(1);
  assign off_ext  = ADDR_W'($signed(bus.offset));

  pc_ras_stack #(
    .DEPTH   (STACK_DEPTH),
    .WIDTH   (ADDR_W),
    .DEPTH_W (DEPTH_W)
  ) u_stack (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (ret_addr),
    .top_o       (top),
    .depth_o     (depth),
    .full_o      (full),
    .empty_o     (empty)
  );

  // Next PC, stack strobes and error flags; clear is applied before set so a new error wins.
  always_comb begin
    addr_d = addr_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    push   = 1'b0;
    pop    = 1'b0;
    if (!bus.stall) begin
      if (bus.clr_err) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      case (act)
        PC_RET: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            pop    = 1'b1;
            addr_d = top;
          end
        end
        PC_CALL: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            push   = 1'b1;
            addr_d = bus.addr_in;
          end
        end
        PC_LD:   addr_d = bus.addr_in;
        PC_BR:   addr_d = addr_q + off_ext;
        PC_CNT:  addr_d = addr_q + ADDR_W'(1);
        default: addr_d = addr_q;
      endcase
    end
  end

  // PC and sticky error registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign bus.addr_out = addr_q;
  assign bus.depth    = depth;
  assign bus.ovf_err  = ovf_q;
  assign bus.unf_err  = unf_q;
endmodule

// File: tb/tb_pc_ras.sv
// Bench for pc_ras: directed vector table, then random stimulus against a queue-based model.
module tb_pc_ras;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_ras_if #(.ADDR_W(8), .OFF_W(8), .DEPTH_W(3)) bus ();

  pc_ras #(
    .ADDR_W      (8),
    .OFF_W       (8),
    .STACK_DEPTH (4),
    .DEPTH_W     (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       r, s, c, l, b, ca, re, cl;
    logic [7:0] ain, off, ea;
    logic [2:0] ed;
    logic       eo, eu;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Model state for the random phase.
  int   m_addr;
  int   m_stack[$];
  bit   m_ovf, m_unf;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic v(input logic r, s, c, l, b, ca, re, cl, input logic [7:0] ain, off, ea,
                   input logic [2:0] ed, input logic eo, eu);
    vec_t t;
    t.r = r; t.s = s; t.c = c; t.l = l; t.b = b; t.ca = ca; t.re = re; t.cl = cl;
    t.ain = ain; t.off = off; t.ea = ea; t.ed = ed; t.eo = eo; t.eu = eu;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, s, c, l, b, ca, re, cl, input logic [7:0] ain, off);
    rst = r; bus.stall = s; bus.count = c; bus.load = l; bus.branch = b;
    bus.call = ca; bus.ret = re; bus.clr_err = cl; bus.addr_in = ain; bus.offset = off;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    //  r s c l b ca re cl  ain    off    addr   d  o  u
    v(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);  // reset
    for (int k = 1; k <= 5; k++) v(1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'(k), 0, 0, 0);
    v(1, 1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h05, 0, 0, 0);  // stall holds
    v(1, 1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h05, 0, 0, 0);
    v(1, 0, 1, 1, 0, 0, 0, 0, 8'h3F, 8'h00, 8'h3F, 0, 0, 0);  // load beats count
    v(1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h40, 0, 0, 0);
    v(1, 0, 0, 1, 0, 0, 0, 0, 8'hFF, 8'h00, 8'hFF, 0, 0, 0);
    v(1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);  // count wrap
    v(1, 0, 0, 1, 0, 0, 0, 0, 8'h10, 8'h00, 8'h10, 0, 0, 0);
    v(1, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'hFC, 8'h0C, 0, 0, 0);  // negative branch
    v(1, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h03, 8'h0F, 0, 0, 0);
    v(1, 0, 0, 1, 0, 0, 0, 0, 8'hFE, 8'h00, 8'hFE, 0, 0, 0);
    v(1, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h05, 8'h03, 0, 0, 0);  // branch wrap
    v(1, 0, 0, 1, 0, 0, 0, 0, 8'h20, 8'h00, 8'h20, 0, 0, 0);
    v(1, 0, 0, 0, 0, 1, 0, 0, 8'h80, 8'h00, 8'h80, 1, 0, 0);  // calls
    v(1, 0, 0, 0, 0, 1, 0, 0, 8'h90, 8'h00, 8'h90, 2, 0, 0);
    v(1, 0, 0, 0, 0, 1, 0, 0, 8'hA0, 8'h00, 8'hA0, 3, 0, 0);
    v(1, 0, 0, 0, 0, 1, 0, 0, 8'hB0, 8'h00, 8'hB0, 4, 0, 0);
    v(1, 0, 0, 0, 0, 1, 0, 0, 8'hC0, 8'h00, 8'hB0, 4, 1, 0);  // overflow
    v(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hB0, 4, 1, 0);  // sticky
    v(1, 1, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'hB0, 4, 1, 0);  // clr ignored in stall
    v(1, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'hB0, 4, 0, 0);  // clr
    v(1, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'hA1, 3, 0, 0);  // returns
    v(1, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h91, 2, 0, 0);
    v(1, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h81, 1, 0, 0);
    v(1, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h21, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h21, 0, 0, 1);  // underflow
    v(1, 0, 0, 1, 0, 0, 0, 0, 8'h20, 8'h00, 8'h20, 0, 0, 1);
    v(1, 0, 0, 0, 0, 1, 0, 0, 8'h80, 8'h00, 8'h80, 1, 0, 1);
    v(1, 0, 0, 0, 0, 1, 1, 0, 8'h55, 8'h00, 8'h21, 0, 0, 1);  // ret beats call
    v(1, 0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h21, 0, 0, 1);  // set beats clr
    v(1, 0, 0, 0, 0, 1, 0, 0, 8'h40, 8'h00, 8'h40, 1, 0, 1);
    v(1, 0, 0, 0, 0, 1, 0, 0, 8'h50, 8'h00, 8'h50, 2, 0, 1);
    v(1, 0, 0, 0, 0, 1, 0, 0, 8'hB0, 8'h00, 8'hB0, 3, 0, 1);
    v(0, 1, 0, 0, 0, 1, 0, 0, 8'h77, 8'h00, 8'h00, 0, 0, 0);  // reset beats stall/call
    v(1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h01, 0, 0, 1);  // stack empty after reset
    v(1, 0, 1, 0, 1, 0, 0, 0, 8'h00, 8'h10, 8'h11, 0, 0, 1);  // branch beats count
    v(1, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h11, 0, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].c, vecs[i].l, vecs[i].b, vecs[i].ca, vecs[i].re,
            vecs[i].cl, vecs[i].ain, vecs[i].off);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_addr", i), int'(bus.addr_out), int'(vecs[i].ea));
      check($sformatf("v%0d_depth", i), int'(bus.depth), int'(vecs[i].ed));
      check($sformatf("v%0d_ovf", i), int'(bus.ovf_err), int'(vecs[i].eo));
      check($sformatf("v%0d_unf", i), int'(bus.unf_err), int'(vecs[i].eu));
    end

    // Random phase: first cycle forces reset so the model starts in sync.
    for (int i = 0; i < 1500; i++) begin
      logic       r, s, c, l, b, ca, re, cl;
      logic [7:0] ain, off;
      r   = (i == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
      s   = ($urandom_range(0, 7) == 0);
      c   = ($urandom_range(0, 2) == 0);
      l   = ($urandom_range(0, 5) == 0);
      b   = ($urandom_range(0, 3) == 0);
      ca  = ($urandom_range(0, 2) == 0);
      re  = ($urandom_range(0, 2) == 0);
      cl  = ($urandom_range(0, 9) == 0);
      ain = 8'($urandom);
      off = 8'($urandom);
      drive(r, s, c, l, b, ca, re, cl, ain, off);

      if (!r) begin
        m_addr = 0; m_ovf = 0; m_unf = 0; m_stack.delete();
      end else if (!s) begin
        if (cl) begin m_ovf = 0; m_unf = 0; end
        if (re) begin
          if (m_stack.size() > 0) m_addr = m_stack.pop_back();
          else m_unf = 1;
        end else if (ca) begin
          if (m_stack.size() < 4) begin
            m_stack.push_back((m_addr + 1) % 256);
            m_addr = int'(ain);
          end else m_ovf = 1;
        end else if (l) m_addr = int'(ain);
        else if (b) m_addr = (m_addr + int'($signed(off))) & 255;
        else if (c) m_addr = (m_addr + 1) % 256;
      end

      @(posedge clk);
      @(negedge clk);
      check($sformatf("r%0d_addr", i), int'(bus.addr_out), m_addr);
      check($sformatf("r%0d_depth", i), int'(bus.depth), m_stack.size());
      check($sformatf("r%0d_ovf", i), int'(bus.ovf_err), int'(m_ovf));
      check($sformatf("r%0d_unf", i), int'(bus.unf_err), int'(m_unf));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Parametrised next-generation program counter for the MCU fetch path: sequential count, absolute load, PC-relative branch, and call/return through an internal return-address stack (RAS).
- Drives the instruction-memory address.
- Fed by the decoder/control FSM with one-cycle control strobes.
- All outputs registered; one clock domain.

Parameters:
- ADDR_W, `INST_DEPTH: program address width in bits.
- OFF_W, 8: signed relative-branch offset width; must be <= ADDR_W.
- STACK_DEPTH, 4: RAS entries; power of two, >= 2.
- DEPTH_W, $clog2(STACK_DEPTH)+1: width of the occupancy output.

Ports:
- clk  in  1  clock; rising-edge active.
- rst  in  1  synchronous, active-low reset.
- stall  in  1  freeze all state when 1.
- count  in  1  increment PC.
- load  in  1  absolute jump to addr_in.
- branch  in  1  relative jump by offset.
- call  in  1  push return address, jump to addr_in.
- ret  in  1  pop return address into PC.
- clr_err  in  1  clear sticky error flags.
- addr_in  in  ADDR_W  jump/call target.
- offset  in  OFF_W  two's-complement branch offset.
- addr_out  out  ADDR_W  current program address.
- depth  out  DEPTH_W  RAS occupancy, 0..STACK_DEPTH.
- ovf_err  out  1  sticky: call attempted while RAS full.
- unf_err  out  1  sticky: ret attempted while RAS empty.

Behaviour:
- Reset is sampled on rising clk with rst==0. Next state: addr_out=0, depth=0, ovf_err=0, unf_err=0. RAS contents are don't-care. Reset overrides stall and all strobes.
- Latency: every update is visible on addr_out one clock after the strobe is sampled. There are no combinational paths from inputs to outputs.
- stall==1: all state holds, including the error flags. clr_err is also ignored.
- When stall==0, exactly one action is taken per cycle, in this priority order:
  1. ret
     - depth>0: addr_out<=RAS[top]; depth<=depth-1.
     - depth==0: addr_out holds; unf_err<=1.
  2. call
     - depth<STACK_DEPTH: RAS[depth]<=addr_out+1 (mod 2^ADDR_W); depth<=depth+1; addr_out<=addr_in.
     - depth==STACK_DEPTH: no push; addr_out holds; ovf_err<=1.
  3. load: addr_out<=addr_in.
  4. branch: addr_out<=addr_out+sign_ext(offset), truncated to ADDR_W (modulo wrap both directions).
  5. count: addr_out<=addr_out+1; wraps from 2^ADDR_W-1 to 0.
  6. none: hold.
- call and ret asserted together: ret wins and call is discarded, with no push and no error.
- Error flags:
  - Sticky until reset or clr_err (while stall==0).
  - If clr_err coincides with a new error event in the same cycle, the set wins.
- RAS is a LIFO indexed by depth. Entries at or above depth are never read.

Decomposition:
- Shared defs: reuse `INST_DEPTH for the ADDR_W default. Add the PC action encoding constants PC_NOP, PC_CNT, PC_BR, PC_LD, PC_CALL, PC_RET, used by the priority encoder and by the bench checker.
- One sub-module, pc_ras_stack:
  - Register-array LIFO: push, pop, push_data, top, depth, full, empty.
  - No error logic; that stays in pc_ras.
- Top level contains the priority encoder, next-PC mux/adder, and error flags.

Test Plan (ADDR_W=8, OFF_W=8, STACK_DEPTH=4):
1. Count and stall:
   - Stimulus: rst=0 for 1 cycle, then rst=1, count=1 for 5 cycles; then stall=1 for 2 cycles.
   - Response: addr_out 00,01,02,03,04,05, then holds 05 for both stall cycles; depth=0 throughout.
2. Load and count wrap:
   - Stimulus: at addr 05, load=1, addr_in=3F with count=1.
   - Response: addr_out 3F, then 40. Then load FF, count -> 00.
3. Relative branch:
   - Stimulus: at 10, offset=FC.
   - Response: 0C. Then offset=03 -> 0F.
   - Stimulus: load FE, then offset=05.
   - Response: 03 (wrap).
4. Nested calls and overflow:
   - Stimulus: at 20, call addr_in=80.
   - Response: addr_out=80, depth=1.
   - Stimulus: calls to 90, A0, B0.
   - Response: depth=4.
   - Stimulus: 5th call to C0.
   - Response: addr_out stays B0, depth=4, ovf_err=1 and stays 1.
   - Stimulus: clr_err=1.
   - Response: ovf_err=0.
5. Returns and underflow:
   - Stimulus: from test 4, ret x4.
   - Response: addr_out A1, 91, 81, 21; depth 3,2,1,0.
   - Stimulus: 5th ret.
   - Response: addr_out holds 21, unf_err=1.
   - Stimulus: call=1 and ret=1 together with depth=1 (stack top 21).
   - Response: addr_out=21, depth=0, ovf_err=0.
6. Reset mid-operation:
   - Stimulus: depth=3, addr_out=B0, unf_err=1; drive rst=0 with call=1 and stall=1.
   - Response: next edge addr_out=00, depth=0, both error flags 0.
